// File: rtl/xalu_seq.sv
// Accumulator-based sequential ALU. Single-cycle ops finish at the accept edge.
// Multi-bit shifts and the shift-add multiply iterate behind busy/done.
module xalu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic             com,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDA, OP_CMP,
    OP_SHL1, OP_SHR1, OP_ROLC, OP_RORC, OP_SHLN, OP_SHRN, OP_MUL, OP_NOT
  } op_e;

  state_e           state;
  logic [WIDTH-1:0] acc, hreg, wk, ph, mcand;
  logic [CW-1:0]    cnt;
  logic             c_f, z_f, nz_f, n_f, eq_f, eq_p, sh_left;

  op_e              op_d;
  logic             accept;
  logic [CW-1:0]    n_sh;
  logic [WIDTH-1:0] add_b, r;
  logic [WIDTH:0]   sum, msum;
  logic             cin, c_n;
  logic [WIDTH-1:0] sh_next, m_ph, m_pl;
  logic             sh_out;

  // {N, NZ, Z} of a result word
  function automatic logic [2:0] nzz(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], &v, ~|v};
  endfunction

  assign op_d   = op_e'(op);
  assign accept = ena & start & ~busy;
  assign y      = com ? ~acc : acc;
  assign hi     = hreg;
  assign flags  = {eq_f, n_f, nz_f, z_f, c_f};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    n_sh  = ({1'b0, b} >= (WIDTH + 1)'(WIDTH)) ? CW'(WIDTH) : CW'(b);
    add_b = (op_d == OP_SUB || op_d == OP_CMP) ? ~b : b;
    cin   = 1'b0;
    if (op_d == OP_ADC) cin = c_f;
    if (op_d == OP_SUB || op_d == OP_CMP) cin = 1'b1;
    sum   = {1'b0, acc} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
    r     = acc;
    c_n   = c_f;
    case (op_d)
      OP_ADD, OP_ADC, OP_SUB, OP_CMP: begin
        r   = sum[WIDTH-1:0];
        c_n = sum[WIDTH];
      end
      OP_AND:  r = acc & b;
      OP_OR:   r = acc | b;
      OP_XOR:  r = acc ^ b;
      OP_LDA:  r = b;
      OP_SHL1: begin r = {acc[WIDTH-2:0], 1'b0}; c_n = acc[WIDTH-1]; end
      OP_SHR1: begin r = {1'b0, acc[WIDTH-1:1]}; c_n = acc[0]; end
      OP_ROLC: begin r = {acc[WIDTH-2:0], c_f};  c_n = acc[WIDTH-1]; end
      OP_RORC: begin r = {c_f, acc[WIDTH-1:1]};  c_n = acc[0]; end
      OP_NOT:  r = ~acc;
      default: r = acc;
    endcase

    sh_next = sh_left ? {wk[WIDTH-2:0], 1'b0} : {1'b0, wk[WIDTH-1:1]};
    sh_out  = sh_left ? wk[WIDTH-1] : wk[0];

    // Shift-add step: {ph, wk} holds the partial product, wk's LSBs the multiplier.
    msum = {1'b0, ph} + (wk[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    m_ph = msum[WIDTH:1];
    m_pl = {msum[0], wk[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      hreg    <= '0;
      wk      <= '0;
      ph      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      c_f     <= 1'b0;
      z_f     <= 1'b1;
      nz_f    <= 1'b0;
      n_f     <= 1'b0;
      eq_f    <= 1'b0;
      eq_p    <= 1'b0;
      sh_left <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            eq_p <= (acc == b);
            case (op_d)
              OP_SHLN, OP_SHRN: begin
                if (n_sh == '0) begin
                  {n_f, nz_f, z_f} <= nzz(acc);
                  eq_f <= (acc == b);
                  done <= 1'b1;
                end else begin
                  state   <= S_SHIFT;
                  busy    <= 1'b1;
                  cnt     <= n_sh;
                  wk      <= acc;
                  sh_left <= (op_d == OP_SHLN);
                end
              end
              OP_MUL: begin
                state <= S_MUL;
                busy  <= 1'b1;
                cnt   <= CW'(WIDTH);
                wk    <= b;
                ph    <= '0;
                mcand <= acc;
              end
              default: begin
                if (op_d != OP_CMP) acc <= r;
                c_f <= c_n;
                {n_f, nz_f, z_f} <= nzz(r);
                eq_f <= (acc == b);
                done <= 1'b1;
              end
            endcase
          end
        end
        S_SHIFT: begin
          wk  <= sh_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            acc   <= sh_next;
            c_f   <= sh_out;
            {n_f, nz_f, z_f} <= nzz(sh_next);
            eq_f  <= eq_p;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          ph  <= m_ph;
          wk  <= m_pl;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            acc   <= m_pl;
            hreg  <= m_ph;
            c_f   <= |m_ph;
            {n_f, nz_f, z_f} <= nzz(m_pl);
            eq_f  <= eq_p;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_seq.sv
// Directed bench for xalu_seq (WIDTH=4): an op-chain vector table plus
// hand-written handshake, freeze and abort sequences.
module tb_xalu_seq;

  localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, AND_ = 4'd3,
                         OR_ = 4'd4, XOR_ = 4'd5, LDA = 4'd6, CMP = 4'd7,
                         SHL1 = 4'd8, SHR1 = 4'd9, ROLC = 4'd10, RORC = 4'd11,
                         SHLN = 4'd12, SHRN = 4'd13, MUL = 4'd14, NOT_ = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, com;
  logic [3:0] op, b;
  logic [3:0] y, hi;
  logic [4:0] flags;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  xalu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .b(b),
    .com(com), .y(y), .hi(hi), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] b;
    int         busy_n;
    logic [3:0] y;
    logic [3:0] hi;
    logic [4:0] flags;   // {EQ, N, NZ, Z, C}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) until busy drops; ends on the negedge after completion.
  task automatic run_op(input logic [3:0] o, input logic [3:0] bv, output int cyc);
    @(negedge clk);
    op = o; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[24];
  int   cyc;
  logic seen_done;

  initial begin
    vecs = '{
      '{LDA,  4'd9,  0, 4'h9, 4'h0, 5'b01000},
      '{ADD,  4'd8,  0, 4'h1, 4'h0, 5'b00001},
      '{ADC,  4'd0,  0, 4'h2, 4'h0, 5'b00000},
      '{LDA,  4'd3,  0, 4'h3, 4'h0, 5'b00000},
      '{SUB,  4'd5,  0, 4'hE, 4'h0, 5'b01000},
      '{CMP,  4'd14, 0, 4'hE, 4'h0, 5'b10011},
      '{AND_, 4'd6,  0, 4'h6, 4'h0, 5'b00001},
      '{OR_,  4'd9,  0, 4'hF, 4'h0, 5'b01101},
      '{XOR_, 4'd5,  0, 4'hA, 4'h0, 5'b01001},
      '{SHL1, 4'd0,  0, 4'h4, 4'h0, 5'b00001},
      '{SHR1, 4'd0,  0, 4'h2, 4'h0, 5'b00000},
      '{NOT_, 4'd0,  0, 4'hD, 4'h0, 5'b01000},
      '{ROLC, 4'd0,  0, 4'hA, 4'h0, 5'b01001},
      '{RORC, 4'd0,  0, 4'hD, 4'h0, 5'b01000},
      '{LDA,  4'd13, 0, 4'hD, 4'h0, 5'b11000},
      '{MUL,  4'd11, 4, 4'hF, 4'h8, 5'b01101},
      '{LDA,  4'd11, 0, 4'hB, 4'h8, 5'b01001},
      '{SHRN, 4'd2,  2, 4'h2, 4'h8, 5'b00001},
      '{SHLN, 4'd7,  4, 4'h0, 4'h8, 5'b00010},
      '{LDA,  4'd15, 0, 4'hF, 4'h8, 5'b01100},
      '{ADD,  4'd1,  0, 4'h0, 4'h8, 5'b00011},
      '{LDA,  4'd6,  0, 4'h6, 4'h8, 5'b00001},
      '{SHLN, 4'd0,  0, 4'h6, 4'h8, 5'b00001},
      '{MUL,  4'd0,  4, 4'h0, 4'h0, 5'b00010}
    };

    // Reset held with start asserted
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; com = 1'b0; op = LDA; b = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y", y, 4'h0);
    check("rst_hi", hi, 4'h0);
    check("rst_flags", flags, 5'b00010);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    com = 1'b1;
    #1;
    check("rst_y_com", y, 4'hF);
    com = 1'b0;
    rst_n = 1'b1; start = 1'b0;

    // Op chain: state carries from one vector to the next
    for (int i = 0; i < 24; i++) begin
      run_op(vecs[i].op, vecs[i].b, cyc);
      check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].busy_n);
      check($sformatf("v%0d_done", i), done, 1'b1);
      check($sformatf("v%0d_y", i), y, vecs[i].y);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_flags", i), flags, vecs[i].flags);
    end

    // MUL: start while busy is ignored, start in the done cycle is accepted
    run_op(LDA, 4'd13, cyc);
    @(negedge clk);
    op = MUL; b = 4'd11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = LDA; b = 4'd0;
    check("b2b_busy_e0", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_busy_e3", busy, 1'b1);
    check("b2b_done_e3", done, 1'b0);
    @(negedge clk);
    check("b2b_done_e4", done, 1'b1);
    check("b2b_busy_e4", busy, 1'b0);
    check("b2b_y_e4", y, 4'hF);
    check("b2b_hi_e4", hi, 4'h8);
    op = LDA; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_y_e5", y, 4'h5);
    check("b2b_done_e5", done, 1'b1);

    // Freeze: ena low for 3 cycles mid-MUL stretches busy to 7 cycles
    run_op(LDA, 4'd13, cyc);
    @(negedge clk);
    op = MUL; b = 4'd11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      if (cyc == 2) ena = 1'b0;
      if (cyc == 5) ena = 1'b1;
      @(negedge clk);
    end
    ena = 1'b1;
    check("frz_busy_cycles", cyc, 7);
    check("frz_done", done, 1'b1);
    check("frz_y", y, 4'hF);
    check("frz_hi", hi, 4'h8);
    check("frz_flags", flags, 5'b01101);

    // Abort: reset at MUL step 2 discards everything, no done
    run_op(LDA, 4'd13, cyc);
    @(negedge clk);
    op = MUL; b = 4'd11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abt_busy", busy, 1'b0);
    check("abt_y", y, 4'h0);
    check("abt_hi", hi, 4'h0);
    check("abt_done", done, 1'b0);
    check("abt_flags", flags, 5'b00010);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abt_no_done", seen_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised sequential ALU: the accumulator-based successor of the 4-bit combinational ALU slice in the kb2ghz Tiny Tapeout design. It holds operand A in an internal accumulator and takes operand B from the input bus. It adds carry-aware arithmetic, compare, rotate-through-carry, multi-bit shifts and a shift-add multiplier behind a start/busy/done handshake. Registered status flags and the one's-complement output mode are retained from the previous slice.

## Interface
- `WIDTH`, default 4: data width; legal range ≥ 2.
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  global enable; when low, all state holds and `start` is ignored.
- `start`  in  1  request; accepted when `ena & start & ~busy`.
- `op`  in  4  opcode, sampled at accept.
- `b`  in  WIDTH  operand B, sampled at accept.
- `com`  in  1  output complement mode; combinational on `y` only.
- `y`  out  WIDTH  `com ? ~A : A`.
- `hi`  out  WIDTH  high half of the last MUL result (H register).
- `flags`  out  5  registered flags {EQ, N, NZ, Z, C}.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse marking result/flags valid.

## Operation
- Op codes, with R = new A:
  - 0 ADD: A+B.
  - 1 ADC: A+B+C.
  - 2 SUB: A+~B+1; C = no-borrow.
  - 3 AND. 4 OR. 5 XOR.
  - 6 LDA: A←B.
  - 7 CMP: flags from A−B; A unchanged.
  - 8 SHL1: shifts in 0; C←A[W-1].
  - 9 SHR1: shifts in 0; C←A[0].
  - 10 ROLC / 11 RORC: rotate through C.
  - 12 SHLN / 13 SHRN: shift by n = min(B, WIDTH); zero fill; C = last bit shifted out.
  - 14 MUL: unsigned {H,A}←A×B; C←(H≠0).
  - 15 NOT: A←~A.
- Arithmetic is WIDTH bits, modulo 2^WIDTH. C is the carry out of bit WIDTH-1.
- Flags update only at op completion:
  - Z = (R==0), NZ = (R all ones), N = R[W-1].
  - EQ = (A==B) with A, B sampled at accept.
  - C is as defined per op. AND/OR/XOR/LDA/NOT leave C unchanged.
  - For CMP, R means the subtraction result.
- H is written only by MUL.
- FSM states:
  - IDLE: accept. Ops 0–11 and 15 complete at the accept edge. SHLN/SHRN with n=0 also complete at accept; A and C are unchanged, and Z/NZ/N/EQ update. SHLN/SHRN with n>0 go to SHIFT; MUL goes to MUL.
  - SHIFT: one bit per cycle; the counter loads n and decrements; the last step goes to IDLE with done.
  - MUL: shift-add, WIDTH steps; the multiplicand, multiplier and partial product are latched at accept; the last step writes {H,A} and flags, then goes to IDLE.
- While `ena`=0 in SHIFT/MUL, the state freezes and resumes when `ena` returns.
- Reset values: A=0, H=0, C=0, Z=1, NZ=0, N=0, EQ=0, busy=0, done=0, state IDLE. `y` = 0 (all ones if `com`=1).
- Reset mid-operation aborts the operation. No done is produced and partial results are discarded.

## Timing
- Edge 0 is the accept edge.
- Single-cycle ops: A and flags are valid after edge 0. `done`=1 for the cycle after edge 0. `busy` stays 0.
- Multi-cycle ops with N steps (N = n or WIDTH):
  - `busy`=1 from after edge 0 through edge N−1, i.e. N cycles.
  - Results are written at edge N. After edge N, `done`=1 and `busy`=0.
  - Total latency is N+1 cycles from the start cycle.
- `start` while `busy`=1 is ignored, with no queueing.
- `start` in the cycle where `done`=1 is accepted, giving back-to-back operation.
- `y`/`hi` track the registers combinationally; `com` has zero-cycle effect.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `start`=1 -> `y`=0, `hi`=0, flags=5'b00010, `busy`=0, `done`=0; `com`=1 -> `y`=4'hF.
- **Add chain (WIDTH=4):**
  - LDA b=9 -> A=9, `done` pulses.
  - ADD b=8 -> A=1, C=1, Z=0.
  - ADC b=0 -> A=2, C=0.
- **Subtract/compare:**
  - A=3, SUB b=5 -> A=4'hE, C=0, N=1.
  - CMP b=14 -> A stays 4'hE, Z=1, C=1, EQ=1.
- **MUL:**
  - A=13, b=11 -> `busy` high 4 cycles; after edge 4 `hi`=8, `y`=4'hF, C=1.
  - A `start` issued while busy is ignored.
  - A `start` issued in the `done` cycle is accepted.
- **Multi-shift:**
  - A=4'hB, SHRN b=2 -> 2 busy cycles, A=2, C=1.
  - SHLN b=7 -> 4 steps, A=0, C=0, Z=1.
  - SHLN b=0 -> single-cycle, A and C unchanged.
- **Abort/freeze:**
  - `ena`=0 for 3 cycles mid-MUL -> busy held; result unchanged versus the uninterrupted case.
  - `rst_n`=0 at step 2 of MUL -> `busy`=0, A=0, H=0, no `done`.
